// File: rtl/prio_enc_rr.sv
// Priority encoder with fixed or round-robin arbitration behind a one-deep output register stage.
// Optional one-hot result output is enabled by defining PRIO_ENC_ONEHOT_EN.
module prio_enc_rr #(
    parameter  int WIDTH = 16,
    localparam int OUT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             rr_mode,
    input  logic [WIDTH-1:0] bin_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [OUT_W-1:0] bin_out,
    output logic             any_out,
    output logic             out_valid,
    input  logic             out_ready
`ifdef PRIO_ENC_ONEHOT_EN
    ,
    output logic [WIDTH-1:0] onehot_out
`endif
);

    localparam logic [WIDTH-1:0] ONE_W = {{(WIDTH-1){1'b0}}, 1'b1};

    function automatic logic [OUT_W-1:0] lowest_set(input logic [WIDTH-1:0] req);
        logic [OUT_W-1:0] idx;
        idx = {OUT_W{1'b0}};
        for (int i = WIDTH - 1; i >= 0; i--) begin
            idx = req[i] ? OUT_W'(i) : idx;
        end
        return idx;
    endfunction

    // Requests above ptr win first; otherwise the search wraps to the lowest set bit, which may be ptr itself.
    function automatic logic [OUT_W-1:0] rr_select(input logic [WIDTH-1:0] req,
                                                   input logic [OUT_W-1:0] ptr);
        logic [WIDTH-1:0] upto_ptr;
        logic [WIDTH-1:0] above_ptr;
        upto_ptr  = ((ONE_W << ptr) << 1) - ONE_W;
        above_ptr = req & ~upto_ptr;
        return (|above_ptr) ? lowest_set(above_ptr) : lowest_set(req);
    endfunction

    logic             out_valid_q, out_valid_d;
    logic [OUT_W-1:0] bin_out_q, bin_out_d;
    logic             any_out_q, any_out_d;
    logic [OUT_W-1:0] ptr_q, ptr_d;
    logic             accept_s;
    logic             win_any_s;
    logic [OUT_W-1:0] win_idx_s;

    assign in_ready  = !out_valid_q || out_ready;
    assign accept_s  = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign bin_out   = bin_out_q;
    assign any_out   = any_out_q;

    // Winner selection for the beat currently presented.
    always_comb begin
        win_any_s = en & (|bin_in);
        if (rr_mode) begin
            win_idx_s = rr_select(bin_in, ptr_q);
        end else begin
            win_idx_s = lowest_set(bin_in);
        end
    end

    // Next state of the output stage and the round-robin pointer.
    always_comb begin
        out_valid_d = out_valid_q;
        bin_out_d   = bin_out_q;
        any_out_d   = any_out_q;
        ptr_d       = ptr_q;
        if (accept_s) begin
            out_valid_d = 1'b1;
            bin_out_d   = win_any_s ? win_idx_s : {OUT_W{1'b0}};
            any_out_d   = win_any_s;
            if (rr_mode && win_any_s) begin
                ptr_d = win_idx_s;
            end else begin
                ptr_d = ptr_q;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State registers; reset discards any in-flight result and points the search at index 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            bin_out_q   <= {OUT_W{1'b0}};
            any_out_q   <= 1'b0;
            ptr_q       <= OUT_W'(WIDTH - 1);
        end else begin
            out_valid_q <= out_valid_d;
            bin_out_q   <= bin_out_d;
            any_out_q   <= any_out_d;
            ptr_q       <= ptr_d;
        end
    end

`ifdef PRIO_ENC_ONEHOT_EN
    logic [WIDTH-1:0] onehot_q, onehot_d;

    assign onehot_out = onehot_q;

    // One-hot copy of the result, loaded alongside bin_out.
    always_comb begin
        if (accept_s) begin
            onehot_d = win_any_s ? (ONE_W << win_idx_s) : {WIDTH{1'b0}};
        end else begin
            onehot_d = onehot_q;
        end
    end

    // One-hot result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            onehot_q <= {WIDTH{1'b0}};
        end else begin
            onehot_q <= onehot_d;
        end
    end
`else
    // Without the one-hot option the encoder presents only bin_out/any_out.
`endif

endmodule

// File: tb/tb_prio_enc_rr.sv
// Scoreboard bench for prio_enc_rr: directed scenarios plus randomized traffic against
// a reference model that walks the request vector index by index.
module tb_prio_enc_rr;
    localparam int W  = 16;
    localparam int OW = $clog2(W);

    logic          clk;
    logic          rst;
    logic          en;
    logic          rr_mode;
    logic [W-1:0]  bin_in;
    logic          in_valid;
    logic          in_ready;
    logic [OW-1:0] bin_out;
    logic          any_out;
    logic          out_valid;
    logic          out_ready;

    prio_enc_rr #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .rr_mode   (rr_mode),
        .bin_in    (bin_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bin_out   (bin_out),
        .any_out   (any_out),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int idx;
        bit any;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   m_ptr = W - 1;
    bit   m_out_valid = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: walk indices in search order and take the first request seen.
    function automatic void ref_pick(input logic [W-1:0] b, input logic e, input logic rm,
                                     input int ptr, output int idx, output bit any);
        int k;
        idx = 0;
        any = 1'b0;
        if (e) begin
            for (int n = 0; n < W; n++) begin
                k = rm ? (ptr + 1 + n) % W : n;
                if (!any && b[k]) begin
                    any = 1'b1;
                    idx = k;
                end
            end
        end
    endfunction

    // One clock: drive at posedge+1, check/accept at negedge.
    task automatic step(input logic iv, input logic e, input logic rm, input logic [W-1:0] b,
                        input logic ordy, input logic r);
        exp_t x;
        bit   acc;
        @(posedge clk);
        #1;
        in_valid  = iv;
        en        = e;
        rr_mode   = rm;
        bin_in    = b;
        out_ready = ordy;
        rst       = r;
        @(negedge clk);
        chk("out_valid", 32'(out_valid), 32'(m_out_valid));
        if (r) begin
            sb.delete();
            m_out_valid = 1'b0;
            m_ptr       = W - 1;
        end else begin
            chk("in_ready", 32'(in_ready), 32'(!m_out_valid || ordy));
            acc = iv && (!m_out_valid || ordy);
            if (acc) begin
                ref_pick(b, e, rm, m_ptr, x.idx, x.any);
                sb.push_back(x);
                if (rm && x.any) m_ptr = x.idx;
                m_out_valid = 1'b1;
            end else if (m_out_valid && ordy) begin
                m_out_valid = 1'b0;
            end
        end
    endtask

    task automatic check_out(input string name, input int idx, input logic any, input logic vld);
        chk({name, ".bin_out"}, 32'(bin_out), 32'(idx));
        chk({name, ".any_out"}, 32'(any_out), 32'(any));
        chk({name, ".out_valid"}, 32'(out_valid), 32'(vld));
    endtask

    // Monitor: compare the presented result with the scoreboard head; pop on handshake.
    always @(negedge clk) begin
        if (!rst && out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("sb_empty_on_valid", 32'(sb.size()), 32'd1);
            end else begin
                chk("mon.bin_out", 32'(bin_out), 32'(sb[0].idx));
                chk("mon.any_out", 32'(any_out), 32'(sb[0].any));
                if (out_ready) void'(sb.pop_front());
            end
        end
    end

    logic [W-1:0] rb;

    initial begin
        rst = 1'b1; en = 1'b0; rr_mode = 1'b0; bin_in = '0; in_valid = 1'b0; out_ready = 1'b0;
        step(0, 0, 0, 16'h0000, 0, 1);
        step(0, 0, 0, 16'h0000, 0, 0);
        check_out("reset", 0, 1'b0, 1'b0);

        // Fixed priority: lowest set index wins.
        step(1, 1, 0, 16'h8010, 1, 0);
        step(0, 0, 0, 16'h0000, 1, 0);
        check_out("fixed_8010", 4, 1'b1, 1'b1);

        // Round-robin after reset: 0,4,15,0.
        step(0, 0, 0, 16'h0000, 1, 1);
        step(1, 1, 1, 16'h8011, 1, 0);
        step(1, 1, 1, 16'h8011, 1, 0);
        check_out("rr_seq0", 0, 1'b1, 1'b1);
        step(1, 1, 1, 16'h8011, 1, 0);
        check_out("rr_seq1", 4, 1'b1, 1'b1);
        step(1, 1, 1, 16'h8011, 1, 0);
        check_out("rr_seq2", 15, 1'b1, 1'b1);
        step(0, 0, 0, 16'h0000, 1, 0);
        check_out("rr_seq3", 0, 1'b1, 1'b1);

        // Backpressure: result holds, in_ready low, then drain + accept together.
        step(1, 1, 0, 16'h0100, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 0, 16'h0002, 0, 0);
            check_out("stall", 8, 1'b1, 1'b1);
            chk("stall.in_ready", 32'(in_ready), 32'd0);
        end
        step(1, 1, 0, 16'h0002, 1, 0);
        chk("drain.in_ready", 32'(in_ready), 32'd1);
        step(0, 0, 0, 16'h0000, 1, 0);
        check_out("after_drain", 1, 1'b1, 1'b1);

        // Zero request, disabled encode, RR pointer untouched by en=0.
        step(1, 1, 0, 16'h0000, 1, 0);
        step(0, 0, 0, 16'h0000, 1, 1);
        check_out("zero_req", 0, 1'b0, 1'b1);
        step(1, 1, 1, 16'h0008, 1, 0);
        step(1, 0, 1, 16'hFFFF, 1, 0);
        check_out("rr_bit3", 3, 1'b1, 1'b1);
        step(1, 1, 1, 16'hFFFF, 1, 0);
        check_out("en_off", 0, 1'b0, 1'b1);
        step(0, 0, 0, 16'h0000, 1, 0);
        check_out("rr_after_en_off", 4, 1'b1, 1'b1);

        // Only the pointer bit set: search wraps back to it.
        step(1, 1, 1, 16'h0020, 1, 0);
        step(1, 1, 1, 16'h0020, 1, 0);
        check_out("rr_self0", 5, 1'b1, 1'b1);
        step(0, 0, 0, 16'h0000, 1, 0);
        check_out("rr_self1", 5, 1'b1, 1'b1);

        // Reset discards a pending grant and restarts the RR search at 0.
        step(0, 0, 0, 16'h0000, 1, 1);
        step(1, 1, 1, 16'h0080, 1, 0);
        step(0, 0, 0, 16'h0000, 0, 0);
        check_out("rr_grant7", 7, 1'b1, 1'b1);
        step(0, 0, 0, 16'h0000, 0, 1);
        step(1, 1, 1, 16'h0081, 1, 0);
        chk("post_rst.out_valid", 32'(out_valid), 32'd0);
        step(0, 0, 0, 16'h0000, 1, 0);
        check_out("post_rst_rr", 0, 1'b1, 1'b1);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 3000; n++) begin
            case ($urandom_range(0, 3))
                0:       rb = 16'h0000;
                1:       rb = W'($urandom);
                2:       rb = 16'h0001 << $urandom_range(0, W - 1);
                default: rb = W'($urandom & $urandom & $urandom);
            endcase
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) != 0),
                 1'($urandom_range(0, 1)), rb, 1'($urandom_range(0, 9) < 7),
                 1'($urandom_range(0, 199) == 0));
        end

        for (int i = 0; i < 4; i++) step(0, 0, 0, 16'h0000, 1, 0);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
